instr_fetch_queue: RTL and testbench

Instruction fetch stage sitting directly downstream of the program counter. Each cycle it may issue a word read to instruction memory at the current PC, advances the PC counter through its enable, and captures returned instructions with their PCs in a small FIFO. The FIFO feeds decode over a valid/ready handshake, and a flush input discards all queued and in-flight fetches on a branch or jump redirect.

---
 rtl/instr_fetch_queue.sv | 181 ++++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction fetch stage directly downstream of the program counter. Each
// cycle it may issue one word read at the current PC (which also advances the
// external PC counter). It captures the returned instruction together with its
// PC in a small FIFO that feeds decode. A flush discards everything queued and
// the read that is in flight.
//
// Handshake (out_valid / out_ready): the head entry transfers on any rising
// edge where out_valid and out_ready are both 1. out_valid never depends on
// out_ready. While out_valid is 1 and out_ready is 0, out_instr and out_pc hold.
//
// Optional feature: define IFQ_STATS_EN to add the stall_count port and its
// back-pressure counter.
//
// Parameters
//   WIDTH      PC and instruction width in bits
//   DEPTH      FIFO entries (power of two, 2..16)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   en           fetch enable (0 stalls new requests only)
//   flush        redirect: kills the queue and the in-flight read
//   pc_in        current word-address PC from the PC counter
//   pc_en        PC counter enable (same as mem_rd_en)
//   mem_rd_en    instruction memory read strobe
//   mem_addr     read address (same as pc_in)
//   mem_rdata    read data, valid exactly one cycle after mem_rd_en
//   out_valid    queue head valid
//   out_ready    decode accepts the head
//   out_instr    head instruction (0 when the queue is empty)
//   out_pc       PC of the head instruction (0 when the queue is empty)
//   stall_count  cycles with en=1 lost to queue back-pressure (IFQ_STATS_EN)
//   state_dbg    FSM state for debug: 0 = RUN, 1 = KILL
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] pc_in,
    output logic             pc_en,
    output logic             mem_rd_en,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
`ifdef IFQ_STATS_EN
    output logic [31:0]      stall_count,
`endif
    output logic             state_dbg
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_KILL = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              inflight;
    logic [WIDTH-1:0]  req_pc;

    logic [WIDTH-1:0]  pc_q    [DEPTH];
    logic [WIDTH-1:0]  instr_q [DEPTH];

    logic              push;
    logic              pop;
    logic [CW:0]       occupancy;
    logic              credit_ok;

    // Head presentation. Outputs are forced to zero when empty so they read
    // zero out of reset and after a flush without resetting the storage.
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? instr_q[rd_ptr] : '0;
    assign out_pc    = out_valid ? pc_q[rd_ptr]    : '0;

    assign pop = out_valid & out_ready;

    // Credit check: slots already used plus the read still returning, minus
    // the slot freed this cycle, must leave room for the new request. This is
    // what guarantees a push never lands on a full queue.
    assign occupancy = {1'b0, count}
                     + {{CW{1'b0}}, inflight}
                     - {{CW{1'b0}}, pop};
    assign credit_ok = (occupancy < DEPTH_W);

    assign mem_rd_en = en & ~flush & ~rst & credit_ok;
    assign pc_en     = mem_rd_en;
    assign mem_addr  = pc_in;

    // Response data is dropped on a flush cycle and during KILL.
    assign push = inflight & ~flush & (state == ST_RUN);

    assign state_dbg = (state == ST_KILL);

    always_comb begin
        state_next = ST_RUN;
        if (flush && inflight) begin
            state_next = ST_KILL;
        end
    end

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
            req_pc   <= '0;
        end else begin
            state    <= state_next;
            // mem_rd_en is already low on a flush cycle, so this also clears
            // inflight on flush.
            inflight <= mem_rd_en;
            if (mem_rd_en) begin
                req_pc <= pc_in;
            end
            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count_next;
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    // Entry storage needs no reset: the head is masked while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]    <= req_pc;
            instr_q[wr_ptr] <= mem_rdata;
        end
    end

`ifdef IFQ_STATS_EN
    // Counts cycles where fetch was wanted but the queue had no credit.
    // Flush cycles are redirects, not back-pressure, so they are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (en && !flush && !mem_rd_en) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic             flush;
  logic [WIDTH-1:0] pc_in;
  logic             pc_en;
  logic             mem_rd_en;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;
`ifdef IFQ_STATS_EN
  logic [31:0]      stall_count;
`endif
  logic             state_dbg;

  // environment: PC counter and instruction memory
  logic             pc_load;
  logic [WIDTH-1:0] pc_val;
  logic [WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0] pc_reg;

  int checks;
  int failures;

  instr_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .flush(flush),
    .pc_in(pc_in),
    .pc_en(pc_en),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
`ifdef IFQ_STATS_EN
    .stall_count(stall_count),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pc_in = pc_reg;

  always @(posedge clk) begin
    if (pc_load) pc_reg <= pc_val;
    else if (flush) pc_reg <= redirect_pc;
    else if (pc_en) pc_reg <= pc_reg + 32'd1;
  end

  // Memory returns 0xA0000000+addr one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= 32'hA000_0000 + mem_addr;
    else mem_rdata <= 32'hDEAD_BEEF;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leaves the bench at 1 time unit after a rising edge with the DUT empty,
  // pc_in = start, and all inputs idle.
  task automatic do_reset(input logic [WIDTH-1:0] start);
    rst = 1'b1; en = 1'b0; flush = 1'b0; out_ready = 1'b0;
    pc_load = 1'b1; pc_val = start;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; pc_load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; flush = 1'b0; out_ready = 1'b1;
    pc_load = 1'b1; pc_val = 32'h0;
    @(posedge clk); #1;
    checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_mem_rd_en: got %b exp 0", mem_rd_en); end
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL reset_pc_en: got %b exp 0", pc_en); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr: got %h exp 0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc: got %h exp 0", out_pc); end
    checks++; if (state_dbg !== 1'b0) begin failures++; $display("FAIL reset_state: got %b exp 0", state_dbg); end
`ifdef IFQ_STATS_EN
    checks++; if (stall_count !== 32'h0) begin failures++; $display("FAIL reset_stall_count: got %0d exp 0", stall_count); end
`endif
    en = 1'b0;
  endtask

  task automatic test_stream;
    do_reset(32'h100);
    en = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (mem_rd_en !== 1'b1) begin failures++; $display("FAIL stream_first_rd_en: got %b exp 1", mem_rd_en); end
    checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL stream_first_addr: got %h exp 100", mem_addr); end
    checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL stream_first_pc_en: got %b exp 1", pc_en); end
    @(posedge clk); #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_cycle1_valid: got %b exp 0", out_valid); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #2;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d]: got %b exp 1", k, out_valid); end
      checks++; if (out_pc !== 32'h100 + k) begin failures++; $display("FAIL stream_pc[%0d]: got %h exp %h", k, out_pc, 32'h100 + k); end
      checks++; if (out_instr !== 32'hA000_0100 + k) begin failures++; $display("FAIL stream_instr[%0d]: got %h exp %h", k, out_instr, 32'hA000_0100 + k); end
    end
    en = 1'b0;
  endtask

  task automatic test_backpressure;
    int issues;
    issues = 0;
    do_reset(32'h200);
    en = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (mem_rd_en) issues++;
      @(posedge clk); #1;
    end
    checks++; if (issues !== 4) begin failures++; $display("FAIL bp_issue_count: got %0d exp 4", issues); end
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL bp_full_pc_en: got %b exp 0", pc_en); end
    checks++; if (out_pc !== 32'h200) begin failures++; $display("FAIL bp_full_head: got %h exp 200", out_pc); end
    out_ready = 1'b1;
    #1;
    checks++; if (mem_rd_en !== 1'b1) begin failures++; $display("FAIL bp_resume_rd_en: got %b exp 1", mem_rd_en); end
    checks++; if (mem_addr !== 32'h204) begin failures++; $display("FAIL bp_resume_addr: got %h exp 204", mem_addr); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_drain_valid[%0d]: got %b exp 1", k, out_valid); end
      checks++; if (out_pc !== 32'h200 + k) begin failures++; $display("FAIL bp_drain_pc[%0d]: got %h exp %h", k, out_pc, 32'h200 + k); end
      checks++; if (out_instr !== 32'hA000_0200 + k) begin failures++; $display("FAIL bp_drain_instr[%0d]: got %h exp %h", k, out_instr, 32'hA000_0200 + k); end
      @(posedge clk); #2;
    end
    en = 1'b0;
  endtask

  // Irregular ready pattern around a near-full queue: every head must be the
  // next sequential PC, and the queue must never run dry once primed.
  task automatic test_back_to_back;
    logic [19:0]      pat;
    logic [WIDTH-1:0] exp_pc;
    pat = 20'b1011_0011_1000_0111_1101;
    exp_pc = 32'h600;
    do_reset(32'h600);
    en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      out_ready = pat[c % 20];
      #1;
      if (c >= 2) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d]: got %b exp 1", c, out_valid); end
      end
      if (out_valid) begin
        checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL b2b_pc[%0d]: got %h exp %h", c, out_pc, exp_pc); end
        checks++; if (out_instr !== 32'hA000_0000 + exp_pc) begin failures++; $display("FAIL b2b_instr[%0d]: got %h exp %h", c, out_instr, 32'hA000_0000 + exp_pc); end
        if (out_ready) exp_pc = exp_pc + 32'd1;
      end
      @(posedge clk); #1;
    end
    checks++; if (exp_pc < 32'h610) begin failures++; $display("FAIL b2b_pop_total: got %h exp >= 610", exp_pc); end
    en = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_flush;
    do_reset(32'h300);
    en = 1'b1; out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (out_pc !== 32'h300) begin failures++; $display("FAIL flush_pre_head: got %h exp 300", out_pc); end
    flush = 1'b1; redirect_pc = 32'h400;
    #1;
    checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL flush_cycle_rd_en: got %b exp 0", mem_rd_en); end
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL flush_cycle_pc_en: got %b exp 0", pc_en); end
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_next_valid: got %b exp 0", out_valid); end
    checks++; if (state_dbg !== 1'b1) begin failures++; $display("FAIL flush_kill_state: got %b exp 1", state_dbg); end
    checks++; if (mem_rd_en !== 1'b1) begin failures++; $display("FAIL flush_kill_issue: got %b exp 1", mem_rd_en); end
    checks++; if (mem_addr !== 32'h400) begin failures++; $display("FAIL flush_redirect_addr: got %h exp 400", mem_addr); end
    @(posedge clk); #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_stale_valid: got %b exp 0", out_valid); end
    checks++; if (state_dbg !== 1'b0) begin failures++; $display("FAIL flush_back_run: got %b exp 0", state_dbg); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_new_valid: got %b exp 1", out_valid); end
    checks++; if (out_pc !== 32'h400) begin failures++; $display("FAIL flush_new_pc: got %h exp 400", out_pc); end
    checks++; if (out_instr !== 32'hA000_0400) begin failures++; $display("FAIL flush_new_instr: got %h exp a0000400", out_instr); end
    @(posedge clk); #2;
    checks++; if (out_pc !== 32'h401) begin failures++; $display("FAIL flush_second_pc: got %h exp 401", out_pc); end
    en = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset(32'h500);
    en = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    checks++; if (out_pc !== 32'h500) begin failures++; $display("FAIL arst_pre_head: got %h exp 500", out_pc); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid: got %b exp 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL arst_instr: got %h exp 0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL arst_pc: got %h exp 0", out_pc); end
    checks++; if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL arst_rd_en: got %b exp 0", mem_rd_en); end
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL arst_pc_en: got %b exp 0", pc_en); end
    #2;
    rst = 1'b0;
    @(posedge clk); #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_old_data_dropped: got %b exp 0", out_valid); end
    @(posedge clk); #2;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_new_valid: got %b exp 1", out_valid); end
    checks++; if (out_pc !== 32'h502) begin failures++; $display("FAIL arst_new_pc: got %h exp 502", out_pc); end
    checks++; if (out_instr !== 32'hA000_0502) begin failures++; $display("FAIL arst_new_instr: got %h exp a0000502", out_instr); end
    en = 1'b0;
  endtask

`ifdef IFQ_STATS_EN
  task automatic test_stats;
    do_reset(32'h700);
    checks++; if (stall_count !== 32'd0) begin failures++; $display("FAIL stats_after_reset: got %0d exp 0", stall_count); end
    en = 1'b1; out_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (stall_count !== 32'd16) begin failures++; $display("FAIL stats_stall_count: got %0d exp 16", stall_count); end
    flush = 1'b1; redirect_pc = 32'h800;
    @(posedge clk); #1;
    flush = 1'b0; en = 1'b0;
    checks++; if (stall_count !== 32'd16) begin failures++; $display("FAIL stats_after_flush: got %0d exp 16", stall_count); end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; en = 1'b0; flush = 1'b0; out_ready = 1'b0;
    pc_load = 1'b1; pc_val = '0; redirect_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef IFQ_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
